// File: rtl/mips_pkg.sv
// Shared MIPS encodings used by the control decoder and the memory-stage load/store unit.
package mips_pkg;

    localparam logic [2:0] LOAD_LB  = 3'd0;
    localparam logic [2:0] LOAD_LBU = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LHU = 3'd3;
    localparam logic [2:0] LOAD_LW  = 3'd4;

    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } acc_size_e;

    // Undefined load/store codes fall through to word size.
    function automatic acc_size_e load_size(input logic [2:0] lt);
        case (lt)
            LOAD_LB, LOAD_LBU: load_size = SizeByte;
            LOAD_LH, LOAD_LHU: load_size = SizeHalf;
            default:           load_size = SizeWord;
        endcase
    endfunction

    function automatic acc_size_e store_size(input logic [1:0] st);
        case (st)
            STORE_SB: store_size = SizeByte;
            STORE_SH: store_size = SizeHalf;
            default:  store_size = SizeWord;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, store byte-enable/data formatting,
// and load byte/half extraction with sign or zero extension.
module lsu_align
    import mips_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  store_type_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic        aligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  rd_type_i,
    input  logic [1:0]  rd_offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_data_o
);

    acc_size_e  size;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        size = is_store_i ? store_size(store_type_i) : load_size(load_type_i);
        case (size)
            SizeByte: aligned_o = 1'b1;
            SizeHalf: aligned_o = ~offset_i[0];
            default:  aligned_o = (offset_i == 2'b00);
        endcase
    end

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        if (is_store_i) begin
            case (store_size(store_type_i))
                SizeByte: begin
                    be_o    = 4'b0001 << offset_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SizeHalf: begin
                    be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
            endcase
        end
    end

    always_comb begin
        byte_sel = rdata_i[{rd_offset_i, 3'b000} +: 8];
        half_sel = rd_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (rd_type_i)
            LOAD_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: load_data_o = {24'h0, byte_sel};
            LOAD_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: load_data_o = {16'h0, half_sel};
            default:  load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns one pipeline access into a byte-masked word access
// on a req/ack data port, stalling upstream until the access completes.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        load_type,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic              accept;
    logic              aligned;
    logic              go;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata;
    logic [31:0]       ext_data;

    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [2:0]        ltype_q;
    logic [1:0]        off_q;
    logic [31:0]       load_data_q;

    // A request with both read and write set is handled as a store.
    assign accept = (state_q == StIdle) & req_valid & (mem_read | mem_write);
    assign go     = accept & aligned;

    lsu_align u_align (
        .is_store_i   (mem_write),
        .load_type_i  (load_type),
        .store_type_i (store_type),
        .offset_i     (addr[1:0]),
        .wdata_i      (wdata),
        .aligned_o    (aligned),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .rd_type_i    (ltype_q),
        .rd_offset_i  (off_q),
        .rdata_i      (mem_rdata),
        .load_data_o  (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (go) state_d = StWait;
            StWait:  if (mem_ack) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall    = (state_q == StWait) | go;
        done     = (state_q == StResp);
        mem_req  = (state_q == StWait);
        misalign = accept & ~aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            ltype_q     <= 3'h0;
            off_q       <= 2'h0;
            load_data_q <= 32'h0;
        end else begin
            if (go) begin
                addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                be_q    <= fmt_be;
                wdata_q <= fmt_wdata;
                we_q    <= mem_write;
                ltype_q <= load_type;
                off_q   <= addr[1:0];
            end
            if ((state_q == StWait) && mem_ack && !we_q) begin
                load_data_q <= ext_data;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign load_data = load_data_q;

endmodule
